alu_control_seq: RTL and testbench

//   Registered, parametrised successor of the combinational ALU controller. Decodes ALUOp/funct into the
//   ALU operation code with a valid/ready handshake, and sequences multi-cycle multu/divu operations with
//   a cycle counter, stalling issue until they finish. Sits between ID/EX issue and the ALU/MDU.

---
 rtl/alu_control_seq.sv | 153 +++++++++++++++
 tb/tb_alu_control_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - registered ALU control decode with multu/divu cycle sequencing
// Single-cycle ops complete one cycle after accept; multu/divu hold the unit for N cycles.
module alu_control_seq #(
  parameter int FUNCT_W    = 6,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  output logic               ready_in,
  input  logic [1:0]         ALUOp,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               flush,
  output logic [FUNCT_W-1:0] alu_funct,
  output logic               valid_out,
  output logic               mdu_busy,
  output logic               illegal
);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  localparam logic [FUNCT_W-1:0] F_ADDU  = FUNCT_W'(6'b001011);
  localparam logic [FUNCT_W-1:0] F_SUBU  = FUNCT_W'(6'b001101);
  localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'(6'b010010);
  localparam logic [FUNCT_W-1:0] F_SLL   = FUNCT_W'(6'b100110);
  localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'b011000);
  localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(6'b011010);

  localparam logic [FUNCT_W-1:0] OP_NONE  = '0;
  localparam logic [FUNCT_W-1:0] OP_ADDU  = FUNCT_W'(6'b001001);
  localparam logic [FUNCT_W-1:0] OP_SUBU  = FUNCT_W'(6'b001010);
  localparam logic [FUNCT_W-1:0] OP_AND   = FUNCT_W'(6'b010001);
  localparam logic [FUNCT_W-1:0] OP_SLL   = FUNCT_W'(6'b100001);
  localparam logic [FUNCT_W-1:0] OP_MULTU = FUNCT_W'(6'b010100);
  localparam logic [FUNCT_W-1:0] OP_DIVU  = FUNCT_W'(6'b011000);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FUNCT_W-1:0] alu_funct_q, alu_funct_d;
  logic               valid_out_q, valid_out_d;
  logic               illegal_q, illegal_d;

  logic [FUNCT_W-1:0] dec_funct;
  logic               dec_illegal;
  logic               dec_multi;
  logic [CNT_W-1:0]   dec_load;
  logic               accept;

  always_comb begin
    dec_funct   = OP_NONE;
    dec_illegal = 1'b0;
    dec_multi   = 1'b0;
    dec_load    = '0;
    unique case (ALUOp)
      2'b00: dec_funct = OP_ADDU;
      2'b01: dec_funct = OP_SUBU;
      2'b10: begin
        unique case (funct)
          F_ADDU:  dec_funct = OP_ADDU;
          F_SUBU:  dec_funct = OP_SUBU;
          F_AND:   dec_funct = OP_AND;
          F_SLL:   dec_funct = OP_SLL;
          F_MULTU: begin
            dec_funct = OP_MULTU;
            dec_multi = 1'b1;
            dec_load  = MUL_LOAD;
          end
          F_DIVU: begin
            dec_funct = OP_DIVU;
            dec_multi = 1'b1;
            dec_load  = DIV_LOAD;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign accept = valid_in && (state_q == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      alu_funct_q <= '0;
      valid_out_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_funct_q <= alu_funct_d;
      valid_out_q <= valid_out_d;
      illegal_q   <= illegal_d;
    end
  end

  // flush wins over everything, including an accept in the same cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_funct_d = alu_funct_q;
    valid_out_d = 1'b0;
    illegal_d   = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            alu_funct_d = dec_funct;
            if (dec_multi) begin
              state_d = S_BUSY;
              cnt_d   = dec_load;
            end else begin
              valid_out_d = 1'b1;
              illegal_d   = dec_illegal;
            end
          end
        end
        S_BUSY: begin
          if (cnt_q <= CNT_ONE) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            valid_out_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    ready_in  = (state_q == S_IDLE);
    mdu_busy  = (state_q == S_BUSY);
    alu_funct = alu_funct_q;
    valid_out = valid_out_q;
    illegal   = illegal_q;
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// tb/tb_alu_control_seq.sv - directed self-checking bench for alu_control_seq
module tb_alu_control_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_in = 1'b0;
  logic       ready_in;
  logic [1:0] ALUOp = 2'b00;
  logic [5:0] funct = 6'h00;
  logic       flush = 1'b0;
  logic [5:0] alu_funct;
  logic       valid_out;
  logic       mdu_busy;
  logic       illegal;

  int tests_run = 0;
  int tests_failed = 0;
  int seen_valid;

  alu_control_seq #(.FUNCT_W(6), .MUL_CYCLES(4), .DIV_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
    .ALUOp(ALUOp), .funct(funct), .flush(flush), .alu_funct(alu_funct),
    .valid_out(valid_out), .mdu_busy(mdu_busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f);
    valid_in = v;
    ALUOp    = op;
    funct    = f;
  endtask

  logic [5:0] t2_funct [4] = '{6'h0D, 6'h12, 6'h26, 6'h0B};
  logic [5:0] t2_exp   [4] = '{6'h0A, 6'h11, 6'h21, 6'h09};

  initial begin
    // 1: reset and first addu
    #12;
    check_eq("rst_alu_funct", alu_funct, 0);
    check_eq("rst_valid_out", valid_out, 0);
    rst = 1'b0;
    #1;
    check_eq("rst_mdu_busy", mdu_busy, 0);
    check_eq("rst_illegal", illegal, 0);
    check_eq("rst_ready_in", ready_in, 1);
    drive(1'b1, 2'b00, 6'h00);
    step();
    check_eq("t1_alu_funct", alu_funct, 6'h09);
    check_eq("t1_valid_out", valid_out, 1);
    check_eq("t1_illegal", illegal, 0);

    // 2: back-to-back R-type
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b10, t2_funct[i]);
      step();
      check_eq($sformatf("t2_alu_funct_%0d", i), alu_funct, t2_exp[i]);
      check_eq($sformatf("t2_valid_%0d", i), valid_out, 1);
    end
    drive(1'b0, 2'b01, 6'h00);
    step();
    check_eq("t2_idle_valid", valid_out, 0);
    check_eq("t2_idle_hold", alu_funct, 6'h09);

    // 3: multu, 4-cycle latency
    drive(1'b1, 2'b10, 6'h18);
    step();
    drive(1'b0, 2'b00, 6'h00);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t3_busy_%0d", i), mdu_busy, 1);
      check_eq($sformatf("t3_ready_%0d", i), ready_in, 0);
      check_eq($sformatf("t3_valid_%0d", i), valid_out, 0);
      check_eq($sformatf("t3_hold_%0d", i), alu_funct, 6'h14);
      step();
    end
    check_eq("t3_done_valid", valid_out, 1);
    check_eq("t3_done_funct", alu_funct, 6'h14);
    check_eq("t3_done_busy", mdu_busy, 0);
    check_eq("t3_done_ready", ready_in, 1);
    step();
    check_eq("t3_after_valid", valid_out, 0);

    // full divu latency: 7 busy cycles then valid
    drive(1'b1, 2'b10, 6'h1A);
    step();
    drive(1'b0, 2'b00, 6'h00);
    seen_valid = 0;
    for (int i = 0; i < 20 && valid_out !== 1'b1; i++) begin
      seen_valid++;
      step();
    end
    check_eq("divu_busy_cycles", seen_valid, 7);
    check_eq("divu_done_funct", alu_funct, 6'h18);

    // 4: divu flushed on cycle 3
    drive(1'b1, 2'b10, 6'h1A);
    step();
    drive(1'b0, 2'b00, 6'h00);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("t4_flush_ready", ready_in, 1);
    check_eq("t4_flush_busy", mdu_busy, 0);
    check_eq("t4_flush_hold", alu_funct, 6'h18);
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid_out) seen_valid++;
      step();
    end
    check_eq("t4_no_valid", seen_valid, 0);
    drive(1'b1, 2'b00, 6'h00);
    step();
    check_eq("t4_addu_funct", alu_funct, 6'h09);
    check_eq("t4_addu_valid", valid_out, 1);

    // flush beats a simultaneous accept
    drive(1'b1, 2'b01, 6'h00);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush_prio_valid", valid_out, 0);
    check_eq("flush_prio_hold", alu_funct, 6'h09);

    // 5: illegal ops
    drive(1'b1, 2'b10, 6'h3F);
    step();
    check_eq("t5_r_funct", alu_funct, 0);
    check_eq("t5_r_illegal", illegal, 1);
    check_eq("t5_r_valid", valid_out, 1);
    drive(1'b1, 2'b11, 6'h0B);
    step();
    check_eq("t5_op11_funct", alu_funct, 0);
    check_eq("t5_op11_illegal", illegal, 1);
    check_eq("t5_op11_valid", valid_out, 1);
    drive(1'b1, 2'b01, 6'h00);
    step();
    check_eq("t5_subu_funct", alu_funct, 6'h0A);
    check_eq("t5_subu_illegal", illegal, 0);

    // 6: async reset mid-divu, valid_in ignored while busy
    drive(1'b1, 2'b10, 6'h1A);
    step();
    drive(1'b1, 2'b00, 6'h00);
    step();
    step();
    check_eq("t6_ignore_funct", alu_funct, 6'h18);
    check_eq("t6_ignore_busy", mdu_busy, 1);
    check_eq("t6_ignore_valid", valid_out, 0);
    drive(1'b0, 2'b00, 6'h00);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_rst_funct", alu_funct, 0);
    check_eq("t6_rst_busy", mdu_busy, 0);
    check_eq("t6_rst_ready", ready_in, 1);
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid_out) seen_valid++;
    end
    check_eq("t6_no_valid", seen_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
